// File: rtl/accelerator_convolution_pkg.sv
// -----------------------------------------------------------------------------
// accelerator_convolution_pkg
// Shared definitions for the matrix-vector circular convolution accelerator:
//   - state_t          : job sequencing states
//   - idx_width()      : ceil(log2(n)) with a floor of 1, for counter/index sizing
//   - signed_max/min() : two's-complement limits of a w-bit word, computed in a
//                        wide container so callers can truncate to their width
// -----------------------------------------------------------------------------
package accelerator_convolution_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_B = 3'd1,
        S_LOAD_A = 3'd2,
        S_MAC    = 3'd3,
        S_EMIT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // Wide enough for the limits of any realistic DATA_SIZE.
    localparam int unsigned SAT_CALC_W = 256;

    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = 32'd1;
        for (int unsigned b = 32'd1; b < 32'd32; b++) begin
            if ((32'd1 << b) < n) begin
                w = b + 32'd1;
            end
        end
        return w;
    endfunction

    function automatic logic signed [SAT_CALC_W-1:0] signed_max(input int unsigned w);
        return (SAT_CALC_W'(1'b1) << (w - 32'd1)) - SAT_CALC_W'(1'b1);
    endfunction

    function automatic logic signed [SAT_CALC_W-1:0] signed_min(input int unsigned w);
        return ~signed_max(w);
    endfunction

endpackage

// File: rtl/accelerator_convolution_mac.sv
// -----------------------------------------------------------------------------
// accelerator_convolution_mac
// Signed multiply-accumulate with synchronous clear, plus the result stage.
// The accumulator is 2*DATA_SIZE + clog2(MAX_J) bits, so a full row of MAX_J
// worst-case products cannot overflow it.
// Optional feature macro: ACCELERATOR_CONVOLUTION_SATURATE_EN
//   defined   -> o_result clamps to the signed DATA_SIZE range
//   undefined -> o_result is the low DATA_SIZE bits (wrap)
// Ports:
//   i_clk, i_rst    clock, asynchronous active-high reset
//   i_clear         zero the accumulator (takes priority over i_en)
//   i_en            accumulate i_a * i_b (both signed)
//   i_a, i_b        operands, DATA_SIZE bits
//   o_result        combinational view of the accumulator, DATA_SIZE bits
// -----------------------------------------------------------------------------
module accelerator_convolution_mac
    import accelerator_convolution_pkg::*;
#(
    parameter int DATA_SIZE = 64,
    parameter int MAX_J     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clear,
    input  logic                 i_en,
    input  logic [DATA_SIZE-1:0] i_a,
    input  logic [DATA_SIZE-1:0] i_b,
    output logic [DATA_SIZE-1:0] o_result
);

    localparam int unsigned PW = 2 * DATA_SIZE;
    localparam int unsigned AW = PW + idx_width(MAX_J);

    logic signed [PW-1:0] w_a_ext;
    logic signed [PW-1:0] w_b_ext;
    logic signed [PW-1:0] w_prod;
    logic signed [AW-1:0] r_acc;

    // Sign-extend first so the full-width product is exact.
    assign w_a_ext = {{DATA_SIZE{i_a[DATA_SIZE-1]}}, i_a};
    assign w_b_ext = {{DATA_SIZE{i_b[DATA_SIZE-1]}}, i_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Accumulator register: clear wins over accumulate.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc <= {AW{1'b0}};
        end else if (i_clear) begin
            r_acc <= {AW{1'b0}};
        end else if (i_en) begin
            r_acc <= r_acc + {{(AW-PW){w_prod[PW-1]}}, w_prod};
        end
    end

`ifdef ACCELERATOR_CONVOLUTION_SATURATE_EN
    localparam logic signed [AW-1:0] SAT_MAX = AW'(signed_max(DATA_SIZE));
    localparam logic signed [AW-1:0] SAT_MIN = AW'(signed_min(DATA_SIZE));

    // Clamp the accumulator into the signed DATA_SIZE range.
    always_comb begin
        o_result = r_acc[DATA_SIZE-1:0];
        if (r_acc > SAT_MAX) begin
            o_result = SAT_MAX[DATA_SIZE-1:0];
        end else if (r_acc < SAT_MIN) begin
            o_result = SAT_MIN[DATA_SIZE-1:0];
        end else begin
            o_result = r_acc[DATA_SIZE-1:0];
        end
    end
`else
    logic w_unused_acc_hi;

    assign o_result        = r_acc[DATA_SIZE-1:0];
    assign w_unused_acc_hi = ^r_acc[AW-1:DATA_SIZE];
`endif

endmodule

// File: rtl/accelerator_matrix_vector_circular_convolution.sv
// -----------------------------------------------------------------------------
// accelerator_matrix_vector_circular_convolution
// Row-wise circular convolution y[i][k] = sum_j a[i][j] * b[(k-j) mod J],
// word-serial, one MAC per cycle. B is loaded once per job and reused for
// every row; each A row is buffered, then J outputs are produced.
// Optional feature macro: ACCELERATOR_CONVOLUTION_SATURATE_EN (see MAC stage).
// Ports:
//   CLK, RST                      clock, asynchronous active-high reset
//   START                         job request, sampled only in IDLE
//   READY / ERROR                 end-of-job pulse / rejected-job flag
//   DATA_A_IN_I_ENABLE            first word of an A row (informational)
//   DATA_A_IN_J_ENABLE, DATA_A_IN A word strobe / data
//   DATA_B_IN_ENABLE, DATA_B_IN   B word strobe / data
//   SIZE_A_I_IN, SIZE_A_J_IN      I rows, J row/vector length (latched on START)
//   DATA_OUT_J_ENABLE, DATA_OUT   output word strobe / data (held between words)
//   DATA_OUT_I_ENABLE             last word of each output row
// -----------------------------------------------------------------------------
module accelerator_matrix_vector_circular_convolution
    import accelerator_convolution_pkg::*;
#(
    parameter int DATA_SIZE = 64,
    parameter int MAX_I     = 16,
    parameter int MAX_J     = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    output logic                 ERROR,
    input  logic                 DATA_A_IN_I_ENABLE,
    input  logic                 DATA_A_IN_J_ENABLE,
    input  logic                 DATA_B_IN_ENABLE,
    output logic                 DATA_OUT_I_ENABLE,
    output logic                 DATA_OUT_J_ENABLE,
    input  logic [DATA_SIZE-1:0] SIZE_A_I_IN,
    input  logic [DATA_SIZE-1:0] SIZE_A_J_IN,
    input  logic [DATA_SIZE-1:0] DATA_A_IN,
    input  logic [DATA_SIZE-1:0] DATA_B_IN,
    output logic [DATA_SIZE-1:0] DATA_OUT
);

    localparam int unsigned JIW = idx_width(MAX_J);      // buffer index
    localparam int unsigned JW  = idx_width(MAX_J + 1);  // holds J itself
    localparam int unsigned IW  = idx_width(MAX_I + 1);  // holds I itself

    state_t               r_state;
    state_t               w_next_state;
    logic [IW-1:0]        r_size_i;
    logic [IW-1:0]        r_row;
    logic [JW-1:0]        r_size_j;
    logic [JW-1:0]        r_cnt;    // word index: B/A load position and MAC j
    logic [JW-1:0]        r_k;      // output column within the row
    logic [JW-1:0]        r_bidx;   // (k - j) mod J, maintained by down-count
    logic                 r_reject;
    logic                 r_ready;
    logic                 r_error;
    logic                 r_out_i_en;
    logic                 r_out_j_en;
    logic [DATA_SIZE-1:0] r_data_out;
    logic [DATA_SIZE-1:0] r_a_buf [MAX_J];
    logic [DATA_SIZE-1:0] r_b_buf [MAX_J];

    logic                 w_size_bad;
    logic                 w_last_cnt;
    logic                 w_last_k;
    logic                 w_last_row;
    logic                 w_b_take;
    logic                 w_a_take;
    logic                 w_mac_clear;
    logic                 w_mac_en;
    logic [DATA_SIZE-1:0] w_a_word;
    logic [DATA_SIZE-1:0] w_b_word;
    logic [DATA_SIZE-1:0] w_result;
    logic                 w_unused_a_i_en;

    assign w_unused_a_i_en = DATA_A_IN_I_ENABLE;

    assign w_size_bad = (SIZE_A_I_IN == {DATA_SIZE{1'b0}})
                     || (SIZE_A_J_IN == {DATA_SIZE{1'b0}})
                     || (SIZE_A_I_IN > DATA_SIZE'(MAX_I))
                     || (SIZE_A_J_IN > DATA_SIZE'(MAX_J));

    assign w_last_cnt = (r_cnt == (r_size_j - JW'(1'b1)));
    assign w_last_k   = (r_k == (r_size_j - JW'(1'b1)));
    assign w_last_row = (r_row == (r_size_i - IW'(1'b1)));

    // Only the enable that matches the current load state is honoured.
    assign w_b_take = (r_state == S_LOAD_B) && DATA_B_IN_ENABLE;
    assign w_a_take = (r_state == S_LOAD_A) && DATA_A_IN_J_ENABLE;

    assign w_mac_en    = (r_state == S_MAC);
    assign w_mac_clear = (w_a_take && w_last_cnt) || (r_state == S_EMIT);

    assign w_a_word = r_a_buf[r_cnt[JIW-1:0]];
    assign w_b_word = r_b_buf[r_bidx[JIW-1:0]];

    accelerator_convolution_mac #(
        .DATA_SIZE (DATA_SIZE),
        .MAX_J     (MAX_J)
    ) u_mac (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_clear  (w_mac_clear),
        .i_en     (w_mac_en),
        .i_a      (w_a_word),
        .i_b      (w_b_word),
        .o_result (w_result)
    );

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_next_state = w_size_bad ? S_DONE : S_LOAD_B;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_LOAD_B: begin
                if (w_b_take && w_last_cnt) begin
                    w_next_state = S_LOAD_A;
                end else begin
                    w_next_state = S_LOAD_B;
                end
            end
            S_LOAD_A: begin
                if (w_a_take && w_last_cnt) begin
                    w_next_state = S_MAC;
                end else begin
                    w_next_state = S_LOAD_A;
                end
            end
            S_MAC: begin
                if (w_last_cnt) begin
                    w_next_state = S_EMIT;
                end else begin
                    w_next_state = S_MAC;
                end
            end
            S_EMIT: begin
                if (!w_last_k) begin
                    w_next_state = S_MAC;
                end else if (w_last_row) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_LOAD_A;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Sizes, counters and the wrapping B index.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_size_i <= {IW{1'b0}};
            r_size_j <= {JW{1'b0}};
            r_cnt    <= {JW{1'b0}};
            r_k      <= {JW{1'b0}};
            r_bidx   <= {JW{1'b0}};
            r_row    <= {IW{1'b0}};
            r_reject <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_size_i <= SIZE_A_I_IN[IW-1:0];
                        r_size_j <= SIZE_A_J_IN[JW-1:0];
                        r_cnt    <= {JW{1'b0}};
                        r_row    <= {IW{1'b0}};
                        r_reject <= w_size_bad;
                    end
                end
                S_LOAD_B: begin
                    if (w_b_take) begin
                        r_cnt <= w_last_cnt ? {JW{1'b0}} : r_cnt + JW'(1'b1);
                    end
                end
                S_LOAD_A: begin
                    if (w_a_take) begin
                        if (w_last_cnt) begin
                            r_cnt  <= {JW{1'b0}};
                            r_k    <= {JW{1'b0}};
                            r_bidx <= {JW{1'b0}};
                        end else begin
                            r_cnt <= r_cnt + JW'(1'b1);
                        end
                    end
                end
                S_MAC: begin
                    r_cnt  <= w_last_cnt ? {JW{1'b0}} : r_cnt + JW'(1'b1);
                    // Down-count with wrap: b index walks k, k-1, ..., 0, J-1, ...
                    r_bidx <= (r_bidx == {JW{1'b0}}) ? r_size_j - JW'(1'b1)
                                                     : r_bidx - JW'(1'b1);
                end
                S_EMIT: begin
                    if (w_last_k) begin
                        r_k   <= {JW{1'b0}};
                        r_row <= r_row + IW'(1'b1);
                    end else begin
                        r_k    <= r_k + JW'(1'b1);
                        r_bidx <= r_k + JW'(1'b1);
                    end
                end
                default: begin
                    r_cnt <= {JW{1'b0}};
                end
            endcase
        end
    end

    // Operand buffers; contents are don't-care after reset.
    always_ff @(posedge CLK) begin
        if (w_b_take) begin
            r_b_buf[r_cnt[JIW-1:0]] <= DATA_B_IN;
        end
        if (w_a_take) begin
            r_a_buf[r_cnt[JIW-1:0]] <= DATA_A_IN;
        end
    end

    // Registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ready    <= 1'b0;
            r_error    <= 1'b0;
            r_out_i_en <= 1'b0;
            r_out_j_en <= 1'b0;
            r_data_out <= {DATA_SIZE{1'b0}};
        end else begin
            r_ready    <= (r_state == S_DONE);
            r_out_j_en <= (r_state == S_EMIT);
            r_out_i_en <= (r_state == S_EMIT) && w_last_k;
            if (r_state == S_EMIT) begin
                r_data_out <= w_result;
            end
            if ((r_state == S_IDLE) && START) begin
                r_error <= 1'b0;
            end else if (r_state == S_DONE) begin
                r_error <= r_reject;
            end
        end
    end

    assign READY             = r_ready;
    assign ERROR             = r_error;
    assign DATA_OUT_I_ENABLE = r_out_i_en;
    assign DATA_OUT_J_ENABLE = r_out_j_en;
    assign DATA_OUT          = r_data_out;

endmodule

// File: tb/tb_accelerator_matrix_vector_circular_convolution.sv
// -----------------------------------------------------------------------------
// Directed bench for accelerator_matrix_vector_circular_convolution, built with
// DATA_SIZE=8 so the overflow case can be exercised. Inputs change on the
// falling edge; outputs are observed on the falling edge.
// -----------------------------------------------------------------------------
module tb_accelerator_matrix_vector_circular_convolution;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          a_i_en;
    logic          a_j_en;
    logic          b_en;
    logic [DW-1:0] size_i;
    logic [DW-1:0] size_j;
    logic [DW-1:0] data_a;
    logic [DW-1:0] data_b;
    logic          ready;
    logic          error;
    logic          out_i_en;
    logic          out_j_en;
    logic [DW-1:0] data_out;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [DW-1:0] q_data[$];
    bit            q_ien[$];
    int            q_cyc[$];

    logic [DW-1:0] exp_basic [6] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd1, 8'd2};

    accelerator_matrix_vector_circular_convolution #(
        .DATA_SIZE (DW),
        .MAX_I     (16),
        .MAX_J     (16)
    ) dut (
        .CLK                (clk),
        .RST                (rst),
        .START              (start),
        .READY              (ready),
        .ERROR              (error),
        .DATA_A_IN_I_ENABLE (a_i_en),
        .DATA_A_IN_J_ENABLE (a_j_en),
        .DATA_B_IN_ENABLE   (b_en),
        .DATA_OUT_I_ENABLE  (out_i_en),
        .DATA_OUT_J_ENABLE  (out_j_en),
        .SIZE_A_I_IN        (size_i),
        .SIZE_A_J_IN        (size_j),
        .DATA_A_IN          (data_a),
        .DATA_B_IN          (data_b),
        .DATA_OUT           (data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output word collector.
    always @(negedge clk) begin
        if (out_j_en === 1'b1) begin
            q_data.push_back(data_out);
            q_ien.push_back(out_i_en);
            q_cyc.push_back(cyc);
        end
    end

    task automatic clear_q();
        q_data.delete();
        q_ien.delete();
        q_cyc.delete();
    endtask

    task automatic start_job(input int i, input int j, output int se);
        start  = 1'b1;
        size_i = DW'(i);
        size_j = DW'(j);
        se     = cyc + 1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // which: 0 = B words, 1 = A row. last_edge = clock count at which the last word is sampled.
    task automatic send_words(input int which, input logic [DW-1:0] w [4], input int n,
                              input bit gapped, output int last_edge);
        last_edge = -1;
        for (int x = 0; x < n; x++) begin
            if (which == 0) begin
                b_en = 1'b1; data_b = w[x];
            end else begin
                a_j_en = 1'b1; a_i_en = (x == 0); data_a = w[x];
            end
            last_edge = cyc + 1;
            @(negedge clk);
            b_en = 1'b0; a_j_en = 1'b0; a_i_en = 1'b0;
            if (gapped) repeat ($urandom_range(2, 0)) @(negedge clk);
        end
    endtask

    // sel: 0 = READY, 1 = DATA_OUT_I_ENABLE
    task automatic wait_for(input int sel, input int budget, output bit seen, output int at_cyc);
        seen   = 1'b0;
        at_cyc = -1;
        for (int t = 0; t < budget && !seen; t++) begin
            @(negedge clk);
            if (((sel == 0) ? ready : out_i_en) === 1'b1) begin
                seen   = 1'b1;
                at_cyc = cyc;
            end
        end
    endtask

    // I=2, J=3, B={1,2,3}, rows {1,0,0},{0,1,0}; optional gaps and ignored noise.
    task automatic drive_basic(input bit gapped, input bit noise, output bit ok,
                               output int rdy_cyc, output int le0);
        int  se, le1, c;
        bit  s1, s2;
        clear_q();
        start_job(2, 3, se);
        if (noise) begin
            a_j_en = 1'b1; data_a = 8'd99;                     // stray A in LOAD_B
            @(negedge clk);
            a_j_en = 1'b0;
            b_en = 1'b1; data_b = 8'd1; a_j_en = 1'b1; data_a = 8'd77;  // both strobes
            @(negedge clk);
            b_en = 1'b0; a_j_en = 1'b0;
            send_words(0, '{8'd2, 8'd3, 8'd0, 8'd0}, 2, gapped, c);
            start = 1'b1; size_i = 8'd1; size_j = 8'd1;        // START in LOAD_A
            @(negedge clk);
            start = 1'b0;
        end else begin
            send_words(0, '{8'd1, 8'd2, 8'd3, 8'd0}, 3, gapped, c);
        end
        send_words(1, '{8'd1, 8'd0, 8'd0, 8'd0}, 3, gapped, le0);
        if (noise) begin
            start = 1'b1;                                      // START in MAC
            @(negedge clk);
            start = 1'b0;
        end
        wait_for(1, 100, s1, c);
        send_words(1, '{8'd0, 8'd1, 8'd0, 8'd0}, 3, gapped, le1);
        wait_for(0, 200, s2, rdy_cyc);
        ok = s1 && s2;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({ready, error, out_i_en, out_j_en, data_out} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_held: got %0h, required 0", {ready, error, out_i_en, out_j_en, data_out});
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (ready !== 1'b0)    begin n_bad++; $display("FAIL reset_ready: got %0b, required 0", ready); end
        n_cmp++; if (error !== 1'b0)    begin n_bad++; $display("FAIL reset_error: got %0b, required 0", error); end
        n_cmp++; if (out_j_en !== 1'b0) begin n_bad++; $display("FAIL reset_jen: got %0b, required 0", out_j_en); end
        n_cmp++; if (out_i_en !== 1'b0) begin n_bad++; $display("FAIL reset_ien: got %0b, required 0", out_i_en); end
        n_cmp++; if (data_out !== 8'd0) begin n_bad++; $display("FAIL reset_data: got %0d, required 0", data_out); end
    endtask

    task automatic test_basic_shift();
        bit ok;
        int rc, le0;
        drive_basic(1'b0, 1'b0, ok, rc, le0);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL basic_timeout: got %0b, required 1", ok); end
        n_cmp++; if (q_data.size() != 6) begin n_bad++; $display("FAIL basic_count: got %0d, required 6", q_data.size()); end
        for (int n = 0; n < 6; n++) begin
            n_cmp++;
            if (n >= q_data.size()) begin
                n_bad++; $display("FAIL basic_word%0d: got none, required %0d", n, exp_basic[n]);
            end else if ({q_data[n], q_ien[n]} !== {exp_basic[n], (n == 2 || n == 5)}) begin
                n_bad++; $display("FAIL basic_word%0d: got %0d/ien %0b, required %0d/ien %0b",
                                  n, q_data[n], q_ien[n], exp_basic[n], (n == 2 || n == 5));
            end
        end
        if (q_cyc.size() == 6) begin
            n_cmp++;
            if (rc != q_cyc[5] + 1) begin n_bad++; $display("FAIL basic_ready_cyc: got %0d, required %0d", rc, q_cyc[5] + 1); end
            n_cmp++;
            if (q_cyc[2] != le0 + 12) begin n_bad++; $display("FAIL basic_latency: got %0d, required %0d", q_cyc[2], le0 + 12); end
        end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL basic_error: got %0b, required 0", error); end
        @(negedge clk);
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL basic_ready_pulse: got %0b, required 0", ready); end
    endtask

    task automatic test_signed_mix();
        bit ok;
        int c, le, rc;
        clear_q();
        start_job(1, 2, c);
        send_words(0, '{8'hFD, 8'h04, 8'h00, 8'h00}, 2, 1'b0, c);
        send_words(1, '{8'h02, 8'hFF, 8'h00, 8'h00}, 2, 1'b0, le);
        wait_for(0, 100, ok, rc);
        n_cmp++;
        if (q_data.size() != 2) begin
            n_bad++; $display("FAIL signed_count: got %0d, required 2", q_data.size());
        end else begin
            if ({q_data[0], q_ien[0]} !== {8'hF6, 1'b0}) begin n_bad++; $display("FAIL signed_y0: got %0h, required f6", q_data[0]); end
            n_cmp++;
            if ({q_data[1], q_ien[1]} !== {8'h0B, 1'b1}) begin n_bad++; $display("FAIL signed_y1: got %0h, required 0b", q_data[1]); end
            n_cmp++;
            if (q_cyc[0] - le != 3) begin n_bad++; $display("FAIL signed_lat0: got %0d, required 3", q_cyc[0] - le); end
            n_cmp++;
            if (q_cyc[1] - le != 6) begin n_bad++; $display("FAIL signed_lat1: got %0d, required 6", q_cyc[1] - le); end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        int c, rc;
        logic [DW-1:0] exp_y;
`ifdef ACCELERATOR_CONVOLUTION_SATURATE_EN
        exp_y = 8'd127;
`else
        exp_y = 8'd32;
`endif
        clear_q();
        start_job(1, 2, c);
        send_words(0, '{8'd100, 8'd100, 8'd0, 8'd0}, 2, 1'b0, c);
        send_words(1, '{8'd100, 8'd100, 8'd0, 8'd0}, 2, 1'b0, c);
        wait_for(0, 100, ok, rc);
        n_cmp++;
        if (q_data.size() < 1) begin
            n_bad++; $display("FAIL overflow_y0: got none, required %0d", exp_y);
        end else if (q_data[0] !== exp_y) begin
            n_bad++; $display("FAIL overflow_y0: got %0d, required %0d", q_data[0], exp_y);
        end
    endtask

    task automatic test_size_reject();
        bit ok;
        int se, rc;
        int bad_i [2] = '{1, 17};
        int bad_j [2] = '{0, 1};
        for (int t = 0; t < 2; t++) begin
            clear_q();
            start_job(bad_i[t], bad_j[t], se);
            wait_for(0, 10, ok, rc);
            n_cmp++;
            if (!ok || rc != se + 1) begin n_bad++; $display("FAIL reject%0d_ready_cyc: got %0d, required %0d", t, rc, se + 1); end
            n_cmp++;
            if (error !== 1'b1) begin n_bad++; $display("FAIL reject%0d_error: got %0b, required 1", t, error); end
            repeat (3) @(negedge clk);
            n_cmp++;
            if ({error, ready} !== 2'b10) begin n_bad++; $display("FAIL reject%0d_hold: got %0b, required 10", t, {error, ready}); end
            n_cmp++;
            if (q_data.size() != 0) begin n_bad++; $display("FAIL reject%0d_words: got %0d, required 0", t, q_data.size()); end
        end
        clear_q();
        start_job(1, 1, se);
        n_cmp++;
        if (error !== 1'b0) begin n_bad++; $display("FAIL reject_clear: got %0b, required 0", error); end
        send_words(0, '{8'd5, 8'd0, 8'd0, 8'd0}, 1, 1'b0, se);
        send_words(1, '{8'd7, 8'd0, 8'd0, 8'd0}, 1, 1'b0, se);
        wait_for(0, 50, ok, rc);
        n_cmp++;
        if (!ok || q_data.size() != 1 || q_data[0] !== 8'd35) begin
            n_bad++; $display("FAIL reject_next_job: got ready %0b words %0d, required 1 word of 35", ok, q_data.size());
        end
    endtask

    task automatic test_robust();
        bit ok;
        int rc, le0;
        drive_basic(1'b1, 1'b1, ok, rc, le0);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL robust_timeout: got %0b, required 1", ok); end
        n_cmp++; if (q_data.size() != 6) begin n_bad++; $display("FAIL robust_count: got %0d, required 6", q_data.size()); end
        for (int n = 0; n < 6 && n < q_data.size(); n++) begin
            n_cmp++;
            if (q_data[n] !== exp_basic[n]) begin
                n_bad++; $display("FAIL robust_word%0d: got %0d, required %0d", n, q_data[n], exp_basic[n]);
            end
        end
    endtask

    task automatic test_reset_mid_job();
        bit ok;
        int c, rc, le0;
        clear_q();
        start_job(2, 3, c);
        send_words(0, '{8'd1, 8'd2, 8'd3, 8'd0}, 3, 1'b0, c);
        send_words(1, '{8'd1, 8'd0, 8'd0, 8'd0}, 3, 1'b0, c);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({ready, error, out_i_en, out_j_en, data_out} !== 12'h000) begin
            n_bad++; $display("FAIL midreset_outputs: got %0h, required 0", {ready, error, out_i_en, out_j_en, data_out});
        end
        @(negedge clk);
        rst = 1'b0;
        wait_for(0, 40, ok, rc);
        n_cmp++;
        if (ok || q_data.size() != 0) begin
            n_bad++; $display("FAIL midreset_no_ready: got ready %0b words %0d, required 0/0", ok, q_data.size());
        end
        drive_basic(1'b0, 1'b0, ok, rc, le0);
        n_cmp++;
        if (!ok || q_data.size() != 6) begin
            n_bad++; $display("FAIL midreset_fresh: got ready %0b words %0d, required 1/6", ok, q_data.size());
        end
        for (int n = 0; n < 6 && n < q_data.size(); n++) begin
            n_cmp++;
            if (q_data[n] !== exp_basic[n]) begin
                n_bad++; $display("FAIL midreset_word%0d: got %0d, required %0d", n, q_data[n], exp_basic[n]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a_i_en = 1'b0; a_j_en = 1'b0; b_en = 1'b0;
        size_i = 8'd0; size_j = 8'd0; data_a = 8'd0; data_b = 8'd0;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic_shift();
        test_signed_mix();
        test_overflow();
        test_size_reject();
        test_robust();
        test_reset_mid_job();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/accelerator_matrix_vector_circular_convolution.md
Name: accelerator_matrix_vector_circular_convolution

Overview:
- Row-wise circular convolution of matrix A (I rows x J columns) with vector B (length J).
- Produces output matrix Y, where y[i][k] = sum over j of a[i][j]*b[(k-j) mod J].
- Streamed, word-serial building block for the NTM addressing path (shift weighting), sized by run-time inputs up to compile-time maxima.
- One MAC per cycle; integer two's-complement arithmetic.

Parameters:
- DATA_SIZE, 64, word width of all data and size ports.
- MAX_I, 16, maximum accepted row count.
- MAX_J, 16, maximum accepted row/vector length (depth of A-row and B buffers).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  single-cycle request; sampled only in IDLE.
- READY  out  1  one-cycle pulse at end of job (normal or error).
- ERROR  out  1  held high from the READY pulse of a rejected job until the next accepted START.
- DATA_A_IN_I_ENABLE  in  1  marks the first word of each A row (informational; counting is internal).
- DATA_A_IN_J_ENABLE  in  1  A word valid.
- DATA_B_IN_ENABLE  in  1  B word valid.
- DATA_OUT_I_ENABLE  out  1  pulses with the last word of each output row.
- DATA_OUT_J_ENABLE  out  1  pulses with every output word.
- SIZE_A_I_IN  in  DATA_SIZE  row count I; latched on START.
- SIZE_A_J_IN  in  DATA_SIZE  row length J, also B length; latched on START.
- DATA_A_IN  in  DATA_SIZE  A word.
- DATA_B_IN  in  DATA_SIZE  B word.
- DATA_OUT  out  DATA_SIZE  Y word; holds its last value between enables.

Behaviour:
- Clocking and reset (already decided): one clock CLK; RST asynchronous, active-high.
- Reset values: all outputs 0, FSM in IDLE, counters 0. Buffer contents undefined.
- RST asserted mid-job aborts the job immediately; no READY is produced.
- States: IDLE, LOAD_B, LOAD_A, MAC, EMIT, DONE.
- IDLE:
  - START=1 latches I and J and clears ERROR.
  - If I=0, J=0, I>MAX_I or J>MAX_J: go to DONE with the error flag set.
  - Otherwise go to LOAD_B.
- LOAD_B: each cycle with DATA_B_IN_ENABLE=1 writes b[cnt]. After the J-th word, go to LOAD_A (row 0).
- LOAD_A:
  - Each cycle with DATA_A_IN_J_ENABLE=1 writes a[cnt].
  - After the J-th word, go to MAC with k=0, accumulator cleared.
  - Gaps in enables are allowed; no timeout.
- MAC:
  - J cycles; cycle j adds a[j]*b[(k-j) mod J].
  - Modular index is computed by a down-counting wrap, never by a divider.
- EMIT (1 cycle):
  - DATA_OUT gets the result; DATA_OUT_J_ENABLE=1.
  - If k=J-1: DATA_OUT_I_ENABLE=1, then go to LOAD_A for the next row, or to DONE after row I-1.
  - Else k++, clear accumulator, return to MAC.
- DONE: READY=1 for one cycle, ERROR=1 if rejected; then go to IDLE.
- Latency: from the last A word of a row, output k appears (k+1)*(J+1) cycles later.
- B is loaded once per job and reused for every row.
- START outside IDLE is ignored.
- Enables outside their load state are ignored.
- A and B enables in the same cycle: only the one matching the current state is taken.
- Arithmetic:
  - Products are full 2*DATA_SIZE signed.
  - Accumulator is 2*DATA_SIZE+clog2(MAX_J) bits and cannot overflow.
  - Result = low DATA_SIZE bits (wrap).

Optional Feature:
- Macro: ACCELERATOR_CONVOLUTION_SATURATE_EN.
- Defined: the EMIT result saturates to the signed DATA_SIZE range (max 2^(DATA_SIZE-1)-1, min -2^(DATA_SIZE-1)).
- Undefined: wrap as above.
- Cycle timing is identical in both cases.

Decomposition:
- Package accelerator_convolution_pkg holds:
  - the state enum;
  - an index-width function, clog2 of MAX_I/MAX_J;
  - signed min/max constants per DATA_SIZE.
- Sub-module accelerator_convolution_mac:
  - clear/enable signed multiply-accumulate;
  - output stage that applies wrap or saturation under the macro.
- The top level holds the FSM, counters, buffers and wrap index.

Test Plan:
- Basic shift: I=2, J=3, B={1,2,3}, A row0={1,0,0}, row1={0,1,0} -> Y row0={1,2,3}, row1={3,1,2}. DATA_OUT_I_ENABLE pulses on words 3 and 6. READY 1 cycle after the last EMIT.
- Signed mix: I=1, J=2, B={-3,4}, A={2,-1} -> Y={-10,11}. Check latency: y0 at 3 cycles and y1 at 6 cycles after the last A word.
- Overflow, DATA_SIZE=8, J=2, A={100,100}, B={100,100} -> y0=32 without the macro, 127 with ACCELERATOR_CONVOLUTION_SATURATE_EN.
- Size reject: START with J=0, and separately with I=MAX_I+1 -> READY and ERROR on the 2nd cycle, no DATA_OUT_J_ENABLE. ERROR clears on the next valid START.
- Robustness:
  - START pulses during LOAD_A and MAC are ignored.
  - Enables gapped randomly give results identical to the basic case.
  - Stray DATA_A_IN_J_ENABLE during LOAD_B is not stored.
- Reset mid-job: assert RST during MAC of row 0 -> all outputs 0 immediately, no READY. A fresh job afterwards produces correct results.
